// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT pipeline: sample width, complex sample type, delay clamping.
// No logic of its own; imported by the delay buffer and its RAM.
package fft_pkg;

   localparam int SAMPLE_W = 16;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] re;
      logic signed [SAMPLE_W-1:0] im;
   } cplx_t;

   // LOAD is the single cycle after reset where the requested delay is captured.
   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } ctl_state_t;

   // Map a requested delay onto the legal range 1..max_d.
   function automatic int unsigned clamp_depth(input int unsigned d, input int unsigned max_d);
      if (d == 0)
         return 1;
      else if (d > max_d)
         return max_d;
      else
         return d;
   endfunction

endpackage

// File: rtl/fft_delay_ram.sv
// DEPTH x WIDTH storage for the delay line: async read, sync write, no reset.
// Read data follows addr combinationally; write lands on the clock edge; no backpressure.
module fft_delay_ram #(
   parameter  int WIDTH  = 32,
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wr_dat,
   output logic [WIDTH-1:0]  rd_dat
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wr_dat;
   end

   assign rd_dat = mem[addr];

endmodule

// File: rtl/fft_delay_buffer.sv
// Complex delay line with runtime delay 1..DEPTH and a valid tag per sample.
// Latency depth_cur enabled cycles; enable=0 freezes all state; flush wins over enable.
module fft_delay_buffer
   import fft_pkg::*;
#(
   parameter  int WIDTH  = SAMPLE_W,
   parameter  int DEPTH  = 16,
   localparam int DSEL_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              flush,
   input  logic [DSEL_W-1:0] depth_sel,
   input  logic              valid_in,
   input  logic [WIDTH-1:0]  x_in_re,
   input  logic [WIDTH-1:0]  x_in_im,
   output logic [WIDTH-1:0]  x_out_re,
   output logic [WIDTH-1:0]  x_out_im,
   output logic              valid_out,
   output logic              primed,
   output logic [DSEL_W-1:0] depth_cur
);

   localparam int PTR_W = $clog2(DEPTH);

   ctl_state_t          state_q;
   ctl_state_t          state_d;
   logic [PTR_W-1:0]    ptr_q;
   logic [DSEL_W-1:0]   fill_q;
   logic [DSEL_W-1:0]   depth_q;
   logic [DSEL_W-1:0]   depth_sel_clamped;
   logic [DSEL_W:0]     fill_inc;
   logic                fill_done;
   logic                primed_q;
   logic [DEPTH-1:0]    tag_q;
   logic [2*WIDTH-1:0]  rd_dat;
   logic                accept;
   logic                ptr_wrap;

   always_comb begin
      state_d = state_q;
      if (state_q == ST_LOAD)
         state_d = ST_RUN;
   end

   assign depth_sel_clamped = DSEL_W'(clamp_depth(32'(depth_sel), 32'(DEPTH)));

   // A sample is only stored in RUN, and a flush on the same edge discards it.
   assign accept    = (state_q == ST_RUN) && enable && !flush;
   assign ptr_wrap  = (DSEL_W'(ptr_q) == (depth_q - DSEL_W'(1)));
   assign fill_inc  = {1'b0, fill_q} + (DSEL_W+1)'(1);
   assign fill_done = (fill_inc >= {1'b0, depth_q});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_LOAD;
         ptr_q    <= '0;
         fill_q   <= '0;
         primed_q <= 1'b0;
         tag_q    <= '0;
         depth_q  <= DSEL_W'(DEPTH);
      end else begin
         state_q <= state_d;
         if ((state_q == ST_LOAD) || flush) begin
            ptr_q    <= '0;
            fill_q   <= '0;
            primed_q <= 1'b0;
            tag_q    <= '0;
            depth_q  <= depth_sel_clamped;
         end else if (enable) begin
            tag_q[ptr_q] <= valid_in;
            ptr_q        <= ptr_wrap ? '0 : ptr_q + PTR_W'(1);
            fill_q       <= fill_done ? depth_q : fill_inc[DSEL_W-1:0];
            primed_q     <= primed_q | fill_done;
         end
      end
   end

   fft_delay_ram #(
      .WIDTH (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk    (clk),
      .we     (accept),
      .addr   (ptr_q),
      .wr_dat ({x_in_re, x_in_im}),
      .rd_dat (rd_dat)
   );

   // Read-before-write: the slot about to be overwritten holds the oldest sample.
   // Gating on the tag hides uninitialised RAM contents.
   assign valid_out = tag_q[ptr_q];
   assign x_out_re  = valid_out ? rd_dat[2*WIDTH-1:WIDTH] : '0;
   assign x_out_im  = valid_out ? rd_dat[WIDTH-1:0]       : '0;
   assign primed    = primed_q;
   assign depth_cur = depth_q;

endmodule

// File: tb/tb_fft_delay_buffer.sv
// Scoreboard bench for fft_delay_buffer: a history-queue model predicts every cycle's outputs.
module tb_fft_delay_buffer;

   localparam int W  = 16;
   localparam int D  = 16;
   localparam int DW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          flush = 1'b0;
   logic [DW-1:0] depth_sel = '0;
   logic          valid_in = 1'b0;
   logic [W-1:0]  x_in_re = '0;
   logic [W-1:0]  x_in_im = '0;
   logic [W-1:0]  x_out_re;
   logic [W-1:0]  x_out_im;
   logic          valid_out;
   logic          primed;
   logic [DW-1:0] depth_cur;

   fft_delay_buffer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .flush     (flush),
      .depth_sel (depth_sel),
      .valid_in  (valid_in),
      .x_in_re   (x_in_re),
      .x_in_im   (x_in_im),
      .x_out_re  (x_out_re),
      .x_out_im  (x_out_im),
      .valid_out (valid_out),
      .primed    (primed),
      .depth_cur (depth_cur)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           v;
      logic [W-1:0] re;
      logic [W-1:0] im;
   } samp_t;

   typedef struct {
      bit            vo;
      logic [W-1:0]  re;
      logic [W-1:0]  im;
      bit            primed;
      logic [DW-1:0] dcur;
   } exp_t;

   samp_t hist[$];
   exp_t  exp_q[$];
   int    m_depth  = D;
   bit    m_loaded = 1'b0;
   int    checks   = 0;
   int    failures = 0;

   function automatic int clampd(input int d);
      if (d < 1) return 1;
      if (d > D) return D;
      return d;
   endfunction

   // Output is the sample accepted m_depth acceptances ago, if there is one.
   function automatic exp_t expect_now();
      exp_t  e;
      samp_t s;
      int    n;
      n = hist.size();
      e.vo = 1'b0;
      e.re = '0;
      e.im = '0;
      e.primed = (n >= m_depth);
      e.dcur = DW'(m_depth);
      if (n >= m_depth) begin
         s = hist[n - m_depth];
         e.vo = s.v;
         if (s.v) begin
            e.re = s.re;
            e.im = s.im;
         end
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic step(input bit en, input bit fl, input bit v,
                       input logic [W-1:0] re, input logic [W-1:0] im, input logic [DW-1:0] ds);
      samp_t s;
      enable = en; flush = fl; valid_in = v; x_in_re = re; x_in_im = im; depth_sel = ds;
      @(posedge clk);
      #1;
      if (rst) begin
         hist.delete(); m_depth = D; m_loaded = 1'b0;
      end else if (!m_loaded) begin
         hist.delete(); m_depth = clampd(int'(ds)); m_loaded = 1'b1;
      end else if (fl) begin
         hist.delete(); m_depth = clampd(int'(ds));
      end else if (en) begin
         s.v = v; s.re = re; s.im = im;
         hist.push_back(s);
      end
      exp_q.push_back(expect_now());
   endtask

   // Assert reset between edges; the pending expectation for this cycle becomes the reset state.
   task automatic async_reset();
      #1;
      rst = 1'b1;
      hist.delete(); m_depth = D; m_loaded = 1'b0;
      if (exp_q.size() > 0)
         exp_q[exp_q.size()-1] = expect_now();
   endtask

   task automatic ramp(input int n, input logic [DW-1:0] ds);
      logic [W-1:0] r;
      for (int k = 1; k <= n; k++) begin
         r = W'(k);
         step(1'b1, 1'b0, 1'b1, r, -r, ds);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("valid_out", 32'(valid_out), 32'(e.vo));
         chk("x_out_re",  32'(x_out_re),  32'(e.re));
         chk("x_out_im",  32'(x_out_im),  32'(e.im));
         chk("primed",    32'(primed),    32'(e.primed));
         chk("depth_cur", 32'(depth_cur), 32'(e.dcur));
      end
   end

   initial begin : stim
      logic [W-1:0] r;
      logic [W-1:0] pat_d [4];
      bit           pat_v [4];
      int           waited;

      // Reset held, then load cycle with enable high: its sample must be ignored.
      step(1'b0, 1'b0, 1'b0, '0, '0, 5'd16);
      step(1'b0, 1'b0, 1'b0, '0, '0, 5'd16);
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b1, 16'd99, 16'd99, 5'd16);
      ramp(40, 5'd16);

      // Enable toggling: idle cycles carry junk that must never be stored.
      step(1'b0, 1'b1, 1'b0, '0, '0, 5'd16);
      for (int k = 1; k <= 40; k++) begin
         r = W'(k);
         step(1'b1, 1'b0, 1'b1, r, -r, 5'd16);
         step(1'b0, 1'b0, 1'b1, 16'hDEAD, 16'hBEEF, 5'd16);
      end

      // Short delay, then clamping at both ends.
      step(1'b0, 1'b1, 1'b0, '0, '0, 5'd3);
      ramp(12, 5'd3);
      step(1'b0, 1'b1, 1'b0, '0, '0, 5'd0);
      ramp(8, 5'd0);
      step(1'b0, 1'b1, 1'b0, '0, '0, 5'd20);
      ramp(20, 5'd20);

      // Valid tag pattern with extreme signed values; untagged data reads as zero.
      pat_d[0] = 16'h7FFF; pat_d[1] = 16'h1234; pat_d[2] = 16'h8000; pat_d[3] = 16'h0005;
      pat_v[0] = 1'b1;     pat_v[1] = 1'b0;     pat_v[2] = 1'b1;     pat_v[3] = 1'b1;
      step(1'b0, 1'b1, 1'b0, '0, '0, 5'd4);
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b0, pat_v[i], pat_d[i], ~pat_d[i], 5'd4);
      for (int i = 0; i < 6; i++)
         step(1'b1, 1'b0, 1'b0, W'($urandom), W'($urandom), 5'd4);

      // Mid-stream async reset, recovery, then flush colliding with enable.
      step(1'b0, 1'b1, 1'b0, '0, '0, 5'd5);
      ramp(8, 5'd5);
      async_reset();
      step(1'b1, 1'b0, 1'b1, 16'h1111, 16'h2222, 5'd5);
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b1, 16'h3333, 16'h3333, 5'd5);
      ramp(8, 5'd5);
      step(1'b1, 1'b1, 1'b1, 16'h4444, 16'h4444, 5'd5);
      ramp(10, 5'd5);

      // Randomised traffic with occasional flushes and resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(59) == 0) begin
            step($urandom_range(1) == 1, 1'b1, 1'b1, W'($urandom), W'($urandom), DW'($urandom_range(31)));
         end else if ($urandom_range(199) == 0) begin
            async_reset();
            step(1'b1, 1'b0, 1'b1, W'($urandom), W'($urandom), DW'($urandom_range(31)));
            rst = 1'b0;
         end else begin
            step($urandom_range(9) < 7, 1'b0, $urandom_range(3) != 0,
                 W'($urandom), W'($urandom), DW'($urandom_range(31)));
         end
      end

      enable = 1'b0;
      flush  = 1'b0;
      waited = 0;
      while (exp_q.size() > 0 && waited < 5) begin
         @(posedge clk);
         waited++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
